// File: rtl/tft_pixel_stream_feeder.sv
// Purpose: buffers a framed RGB pixel stream and feeds it to the panel on the timing generator's DENA.
// Latency: DENA_in/HD_in/VD_in and the popped pixel appear one cycle later on DENA/HD/VD/Red/Green/Blue.
// Backpressure: s_tready follows FIFO fullness; it is forced high while hunting for SOF so junk drains.
module tft_pixel_stream_feeder #(
  parameter int HPIXELS = 800,
  parameter int VLINES  = 480,
  parameter int AW      = 10
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic [23:0]   s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic          s_tuser,
  input  logic          s_tlast,
  input  logic          DENA_in,
  input  logic          HD_in,
  input  logic          VD_in,
  output logic          DENA,
  output logic          HD,
  output logic          VD,
  output logic [7:0]    Red,
  output logic [7:0]    Green,
  output logic [7:0]    Blue,
  output logic          underflow,
  output logic          sync_err,
  input  logic          err_clr,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = (HPIXELS > 1) ? $clog2(HPIXELS) : 1;
  localparam int LW    = (VLINES > 1) ? $clog2(VLINES) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(HPIXELS - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(VLINES - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {SEEK, WAIT_VS, ARMED, RUN} state_t;

  state_t        state, state_nxt;
  logic [25:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          ready_en;
  logic [CW-1:0] col, col_nxt, exp_col;
  logic [LW-1:0] line, line_nxt, exp_line;
  logic          exp_sof, exp_eol;
  logic          accept, wr_en, pop, flush, uf_set, se_set, show_pix;
  logic [25:0]   head;

  // Show-ahead read: the head word is visible the cycle after it is written.
  assign head     = mem[rd_ptr];
  assign s_tready = ready_en && ((state == SEEK) || (level != FULL_LVL));
  assign accept   = s_tvalid && s_tready;

  // Sequencer: lock-on, VD arming, pop control and marker/underflow checks.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    uf_set    = 1'b0;
    se_set    = 1'b0;
    show_pix  = 1'b0;
    col_nxt   = col;
    line_nxt  = line;
    // The first pop after arming is always the top-left pixel.
    exp_col   = (state == ARMED) ? '0 : col;
    exp_line  = (state == ARMED) ? '0 : line;
    exp_sof   = (exp_col == '0) && (exp_line == '0);
    exp_eol   = (exp_col == COL_LAST);
    case (state)
      SEEK: begin
        if (accept && s_tuser) begin
          wr_en     = 1'b1;
          state_nxt = WAIT_VS;
        end
      end
      WAIT_VS: begin
        wr_en = accept;
        if (VD && !VD_in) state_nxt = ARMED;
      end
      ARMED, RUN: begin
        wr_en = accept;
        if (DENA_in) begin
          if (level == '0) begin
            uf_set    = 1'b1;
            flush     = 1'b1;
            state_nxt = SEEK;
          end else begin
            pop = 1'b1;
            if ((head[25] != exp_sof) || (head[24] != exp_eol)) begin
              se_set    = 1'b1;
              flush     = 1'b1;
              state_nxt = SEEK;
            end else begin
              show_pix  = 1'b1;
              state_nxt = RUN;
              if (exp_col == COL_LAST) begin
                col_nxt  = '0;
                line_nxt = (exp_line == LINE_LAST) ? '0 : exp_line + 1'b1;
              end else begin
                col_nxt  = exp_col + 1'b1;
                line_nxt = exp_line;
              end
            end
          end
        end
      end
      default: state_nxt = SEEK;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) state <= SEEK;
    else       state <= state_nxt;
  end

  // FIFO storage; words written in a flushing cycle are dropped with the rest.
  always_ff @(posedge CLK) begin
    if (wr_en && !flush) mem[wr_ptr] <= {s_tuser, s_tlast, s_tdata};
  end

  // FIFO pointers and occupancy; a flush (entry into SEEK) empties it.
  always_ff @(posedge CLK) begin
    if (Reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

  // Raster position of the next pixel to be popped.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      col  <= '0;
      line <= '0;
    end else begin
      col  <= col_nxt;
      line <= line_nxt;
    end
  end

  // s_tready stays low for the first cycle after reset releases.
  always_ff @(posedge CLK) begin
    ready_en <= !Reset;
  end

  // Re-timed strobes and pixel; RGB holds while DENA is low, black on any fault or when unlocked.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      DENA               <= 1'b0;
      HD                 <= 1'b0;
      VD                 <= 1'b0;
      {Red, Green, Blue} <= '0;
    end else begin
      DENA <= DENA_in;
      HD   <= HD_in;
      VD   <= VD_in;
      if (DENA_in) {Red, Green, Blue} <= show_pix ? head[23:0] : 24'h0;
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      underflow <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      underflow <= (underflow && !err_clr) || uf_set;
      sync_err  <= (sync_err && !err_clr) || se_set;
    end
  end

endmodule

// File: tb/tb_tft_pixel_stream_feeder.sv
// Bench for tft_pixel_stream_feeder on a 4x2 raster with an 8-deep FIFO.
// Directed scenarios plus randomized frames, checked every cycle against a queue-based model.
// Source valid is randomly throttled; the model decides which words the DUT must accept.
module tb_tft_pixel_stream_feeder;
  localparam int H = 4, V = 2, AW = 3, DEPTH = 8;
  localparam int M_SEEK = 0, M_WAIT = 1, M_ARMED = 2, M_RUN = 3;

  logic CLK = 1'b0;
  logic Reset, s_tvalid, s_tready, s_tuser, s_tlast, DENA_in, HD_in, VD_in;
  logic DENA, HD, VD, underflow, sync_err, err_clr;
  logic [23:0] s_tdata;
  logic [7:0] Red, Green, Blue;
  logic [AW:0] level;

  always #5 CLK = ~CLK;

  tft_pixel_stream_feeder #(.HPIXELS(H), .VLINES(V), .AW(AW)) dut (
    .CLK(CLK), .Reset(Reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tuser(s_tuser), .s_tlast(s_tlast), .DENA_in(DENA_in), .HD_in(HD_in), .VD_in(VD_in),
    .DENA(DENA), .HD(HD), .VD(VD), .Red(Red), .Green(Green), .Blue(Blue),
    .underflow(underflow), .sync_err(sync_err), .err_clr(err_clr), .level(level));

  typedef struct packed {logic sof; logic eol; logic [23:0] rgb;} word_t;
  typedef struct packed {logic dena; logic hd; logic vd; logic clr; logic rst;} tim_t;

  word_t src[$];
  tim_t  tq[$];
  logic [23:0] shown[$];
  int errors = 0, checks = 0;
  logic rand_clr = 1'b0;

  // Reference model: FIFO as a queue, raster position as a plain pixel index.
  word_t mq[$];
  int mmode = M_SEEK, mpos = 0;
  logic m_rdy_en = 1'b0, m_dena = 1'b0, m_hd = 1'b0, m_vd = 1'b0, m_uf = 1'b0, m_se = 1'b0;
  logic [23:0] m_rgb = 24'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_tready();
    return m_rdy_en && ((mmode == M_SEEK) || (mq.size() < DEPTH));
  endfunction

  function automatic tim_t mk_tim(logic dena, logic hd, logic vd, logic clr, logic rst);
    tim_t t;
    t.dena = dena; t.hd = hd; t.vd = vd; t.clr = clr; t.rst = rst;
    return t;
  endfunction

  task automatic model_step(input logic v, input word_t w, input tim_t t, input logic clr,
                            output logic acc);
    logic uf_new, se_new, flush;
    word_t h;
    int ep, mode0;
    uf_new = 1'b0; se_new = 1'b0; flush = 1'b0;
    acc = v && m_tready();
    mode0 = mmode;
    if (t.rst) begin
      acc = 1'b0;
      mq.delete();
      mmode = M_SEEK; mpos = 0; m_rdy_en = 1'b0;
      m_dena = 1'b0; m_hd = 1'b0; m_vd = 1'b0; m_rgb = 24'h0; m_uf = 1'b0; m_se = 1'b0;
    end else begin
      if (mode0 == M_SEEK) begin
        if (acc && w.sof) begin mq.push_back(w); mmode = M_WAIT; end
      end else if (mode0 == M_WAIT) begin
        if (acc) mq.push_back(w);
        if (m_vd && !t.vd) mmode = M_ARMED;
      end else begin
        if (t.dena) begin
          ep = (mode0 == M_ARMED) ? 0 : mpos;
          if (mq.size() == 0) begin
            uf_new = 1'b1; flush = 1'b1;
          end else begin
            h = mq.pop_front();
            if (h.sof != (ep == 0) || h.eol != ((ep % H) == H - 1)) begin
              se_new = 1'b1; flush = 1'b1;
            end else begin
              m_rgb = h.rgb; mpos = (ep + 1) % (H * V); mmode = M_RUN;
            end
          end
          if (flush) begin m_rgb = 24'h0; mq.delete(); mmode = M_SEEK; end
        end
        if (acc && !flush) mq.push_back(w);
      end
      if (t.dena && (mode0 == M_SEEK || mode0 == M_WAIT)) m_rgb = 24'h0;
      m_uf = (m_uf && !clr) || uf_new;
      m_se = (m_se && !clr) || se_new;
      m_dena = t.dena; m_hd = t.hd; m_vd = t.vd; m_rdy_en = 1'b1;
    end
  endtask

  task automatic run(input int n);
    tim_t t; word_t w; logic v, clr, acc;
    for (int i = 0; i < n; i++) begin
      t = (tq.size() > 0) ? tq.pop_front() : mk_tim(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      v = (src.size() > 0) && !t.rst && ($urandom_range(3) != 0);
      if (src.size() > 0) w = src[0];
      else begin w.sof = 1'b0; w.eol = 1'b0; w.rgb = 24'($urandom); end
      clr = t.clr || (rand_clr && ($urandom_range(31) == 0));
      Reset = t.rst; s_tvalid = v; s_tdata = w.rgb; s_tuser = w.sof; s_tlast = w.eol;
      DENA_in = t.dena; HD_in = t.hd; VD_in = t.vd; err_clr = clr;
      model_step(v, w, t, clr, acc);
      if (acc) void'(src.pop_front());
      @(posedge CLK); #1;
      check("s_tready", s_tready, m_tready());
      check("DENA", DENA, m_dena);
      check("HD", HD, m_hd);
      check("VD", VD, m_vd);
      check("rgb", {Red, Green, Blue}, m_rgb);
      check("underflow", underflow, m_uf);
      check("sync_err", sync_err, m_se);
      check("level", level, mq.size());
      if (DENA) shown.push_back({Red, Green, Blue});
    end
  endtask

  task automatic drain();
    int b = 0;
    while (src.size() > 0 && b < 200) begin run(1); b++; end
    check("drain_timeout", src.size(), 0);
  endtask

  task automatic add_idle(input int n);
    repeat (n) tq.push_back(mk_tim(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
  endtask

  // One frame of timing: VD pulse, then V lines of HD plus a DENA burst of H.
  task automatic add_frame(input int npix, input int rst_pix);
    int k = 0;
    add_idle(1 + $urandom_range(2));
    tq.push_back(mk_tim(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tq.push_back(mk_tim(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    add_idle(1 + $urandom_range(2));
    for (int l = 0; l < V; l++) begin
      tq.push_back(mk_tim(1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      add_idle($urandom_range(2));
      for (int c = 0; c < H; c++) begin
        if (k == npix) return;
        if (k == rst_pix) begin
          tq.push_back(mk_tim(1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
          tq.push_back(mk_tim(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        end else tq.push_back(mk_tim(1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        k++;
      end
      add_idle(1 + $urandom_range(2));
    end
  endtask

  task automatic add_src_frame(input int n, input int bad_eol, input logic seq);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.sof = (i == 0);
      w.eol = ((i % H) == H - 1) || (i == bad_eol);
      w.rgb = seq ? 24'(i + 1) : 24'($urandom);
      src.push_back(w);
    end
  endtask

  task automatic add_junk(input int n);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.sof = 1'b0; w.eol = 1'($urandom); w.rgb = 24'($urandom);
      src.push_back(w);
    end
  endtask

  function automatic logic [23:0] shown_at(input int k);
    return (k < shown.size()) ? shown[k] : 24'hDEAD00;
  endfunction

  task automatic show_frame();
    shown.delete();
    add_idle(2);
    add_frame(H * V, -1);
    run(tq.size() + 2);
  endtask

  initial begin
    Reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
    DENA_in = 1'b0; HD_in = 1'b0; VD_in = 1'b1; err_clr = 1'b0;

    // Reset state, then s_tready one cycle after release.
    repeat (3) tq.push_back(mk_tim(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    run(3);
    check("rst_tready", s_tready, 0);
    check("rst_level", level, 0);
    check("rst_rgb", {Red, Green, Blue}, 0);
    run(1);
    check("tready_after_rst", s_tready, 1);

    // Normal frame 1..8.
    add_src_frame(8, -1, 1'b1);
    drain();
    show_frame();
    check("norm_count", shown.size(), 8);
    for (int k = 0; k < 8; k++) check("norm_pix", shown_at(k), 24'(k + 1));
    check("norm_uf", underflow, 0);
    check("norm_se", sync_err, 0);

    // Underflow: only 5 of 8 pixels, then recovery and clear.
    add_src_frame(5, -1, 1'b1);
    drain();
    show_frame();
    check("uf_pix5", shown_at(4), 24'd5);
    check("uf_pix6_black", shown_at(5), 0);
    check("uf_flag", underflow, 1);
    check("uf_level", level, 0);
    add_src_frame(8, -1, 1'b1);
    drain();
    show_frame();
    check("uf_resync_first", shown_at(0), 24'd1);
    check("uf_resync_last", shown_at(7), 24'd8);
    tq.push_back(mk_tim(1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    run(1);
    check("uf_clr", underflow, 0);

    // Marker error: eol on column 2.
    add_src_frame(8, 2, 1'b1);
    drain();
    show_frame();
    check("se_pix1", shown_at(1), 24'd2);
    check("se_pix2_black", shown_at(2), 0);
    check("se_flag", sync_err, 1);
    add_src_frame(8, -1, 1'b1);
    drain();
    show_frame();
    check("se_resync_first", shown_at(0), 24'd1);
    tq.push_back(mk_tim(1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    run(1);
    check("se_clr", sync_err, 0);

    // Reset mid-RUN at the third pixel.
    add_src_frame(8, -1, 1'b1);
    drain();
    add_idle(2);
    add_frame(2, -1);
    tq.push_back(mk_tim(1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    run(tq.size());
    check("mid_rst_dena", DENA, 0);
    check("mid_rst_rgb", {Red, Green, Blue}, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_tready", s_tready, 0);
    run(1);
    check("mid_rst_tready_after", s_tready, 1);

    // Lock-on: junk words are discarded before SOF.
    add_junk(3);
    drain();
    check("lock_level", level, 0);
    add_src_frame(8, -1, 1'b1);
    drain();
    show_frame();
    check("lock_first", shown_at(0), 24'd1);

    // Full/backpressure, then two continuous frames.
    add_src_frame(8, -1, 1'b0);
    add_src_frame(8, -1, 1'b0);
    run(24);
    check("full_level", level, DEPTH);
    check("full_tready", s_tready, 0);
    check("full_pending", src.size(), 8);
    add_frame(H * V, -1);
    add_frame(H * V, -1);
    run(tq.size() + 4);

    // Randomized frames with random faults.
    rand_clr = 1'b1;
    for (int it = 0; it < 10; it++) begin
      int f;
      src.delete();
      f = $urandom_range(4);
      case (f)
        1: add_src_frame($urandom_range(1, 7), -1, 1'b0);
        2: add_src_frame(8, $urandom_range(0, 2), 1'b0);
        3: begin add_junk(3); add_src_frame(8, -1, 1'b0); end
        default: add_src_frame(8, -1, 1'b0);
      endcase
      add_idle(14);
      add_frame(H * V, (f == 4) ? int'($urandom_range(0, 7)) : -1);
      run(tq.size() + 2);
    end
    rand_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
